gnn_result_collector: RTL and testbench

- Sink end of the GNN datapath top. Holds in_ready to the GNN top for the duration of an inference.
- Captures the eight 21-bit layer-2 results (out0/out1 × 4 nodes) as their per-result ready flags assert.
- Then streams them out one word per transfer over a valid/ready interface, tagged with node, index and a per-node class bit.
- Sits between the GNN top and the host/readback logic.

---
 rtl/gnn_pkg.sv | 24 ++
 rtl/gnn_result_collector_if.sv | 37 +++
 rtl/gnn_rc_slot.sv | 27 ++
 rtl/gnn_result_collector.sv | 139 +++++++++++++
 tb/tb_gnn_result_collector.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/gnn_pkg.sv
// Shared types for the GNN result collector: sizes, FSM states and the stream word layout.
// Sized for the 4-node, 21-bit layer-2 output of the GNN top.
package gnn_pkg;
  localparam int NUM_NODES   = 4;
  localparam int DATA_W      = 21;
  localparam int NUM_RESULTS = 2 * NUM_NODES;
  localparam int NODE_W      = $clog2(NUM_NODES);
  localparam int PTR_W       = $clog2(NUM_RESULTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic              missing;
    logic              last;
    logic              cls;
    logic [NODE_W-1:0] node;
    logic              idx;
    logic [DATA_W-1:0] data;
  } res_word_t;
endpackage

// File: rtl/gnn_result_collector_if.sv
// Handshake and data bundle between the GNN top, the collector and the host readback side.
// The collector uses the slave view; the producer/host side uses the master view.
interface gnn_result_collector_if #(
  parameter int NUM_NODES = gnn_pkg::NUM_NODES,
  parameter int DATA_W    = gnn_pkg::DATA_W
);
  localparam int NODE_W = $clog2(NUM_NODES);

  logic                        start;
  logic                        in_ready;
  logic [NUM_NODES*DATA_W-1:0] out0_bus;
  logic [NUM_NODES*DATA_W-1:0] out1_bus;
  logic [NUM_NODES-1:0]        out10_rdy;
  logic [NUM_NODES-1:0]        out11_rdy;
  logic                        res_valid;
  logic                        res_ready;
  logic [DATA_W-1:0]           res_data;
  logic [NODE_W-1:0]           res_node;
  logic                        res_idx;
  logic                        res_class;
  logic                        res_missing;
  logic                        res_last;
  logic                        busy;
  logic                        timeout;

  modport slave (
    input  start, out0_bus, out1_bus, out10_rdy, out11_rdy, res_ready,
    output in_ready, res_valid, res_data, res_node, res_idx, res_class,
           res_missing, res_last, busy, timeout
  );

  modport master (
    output start, out0_bus, out1_bus, out10_rdy, out11_rdy, res_ready,
    input  in_ready, res_valid, res_data, res_node, res_idx, res_class,
           res_missing, res_last, busy, timeout
  );
endinterface

// File: rtl/gnn_rc_slot.sv
// One result capture register with its "already captured" flag.
// Captures the first value seen while enabled and ready; later changes are ignored until clr.
module gnn_rc_slot #(
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rdy,
  input  logic              collect_en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (collect_en && rdy && !valid) begin
      q     <= d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/gnn_result_collector.sv
// Collects the eight layer-2 results of one inference, then streams them out one word per
// transfer tagged with node, index, class and missing flags; a timeout forces the drain.
module gnn_result_collector
  import gnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gnn_result_collector_if.slave io
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_RESULTS - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             timeout_q, timeout_nxt;

  logic [NUM_RESULTS-1:0] mask;
  logic [NUM_RESULTS-1:0] rdy_vec;
  logic [DATA_W-1:0]      d_vec [NUM_RESULTS];
  logic [DATA_W-1:0]      q_vec [NUM_RESULTS];
  logic [NUM_NODES-1:0]   node_cls;
  logic                   slot_clr;
  logic                   collect_en;
  logic                   xfer;
  res_word_t              word;

  assign slot_clr   = (state == ST_IDLE) && io.start;
  assign collect_en = (state == ST_COLLECT);
  assign xfer       = (state == ST_DRAIN) && io.res_ready;

  // Slot p holds node p>>1, out0 when p is even and out1 when odd, matching drain order.
  for (genvar p = 0; p < NUM_RESULTS; p++) begin : g_slot
    localparam int N = p / 2;
    if (p % 2 == 0) begin : g_out0
      assign rdy_vec[p] = io.out10_rdy[N];
      assign d_vec[p]   = io.out0_bus[N*DATA_W +: DATA_W];
    end else begin : g_out1
      assign rdy_vec[p] = io.out11_rdy[N];
      assign d_vec[p]   = io.out1_bus[N*DATA_W +: DATA_W];
    end

    gnn_rc_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (slot_clr),
      .rdy        (rdy_vec[p]),
      .collect_en (collect_en),
      .d          (d_vec[p]),
      .q          (q_vec[p]),
      .valid      (mask[p])
    );
  end

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_cls
    assign node_cls[n] = mask[2*n] && mask[2*n+1] &&
                         ($signed(q_vec[2*n+1]) > $signed(q_vec[2*n]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      ptr       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      ptr       <= ptr_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    ptr_nxt     = ptr;
    timeout_nxt = timeout_q;
    case (state)
      ST_IDLE: begin
        if (io.start) begin
          state_nxt   = ST_COLLECT;
          timer_nxt   = '0;
          ptr_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_COLLECT: begin
        // Completion looks at this cycle's captures too, so it wins over a same-cycle timeout.
        if (&(mask | rdy_vec)) begin
          state_nxt = ST_DRAIN;
        end else if (timer == TMR_LAST) begin
          state_nxt   = ST_DRAIN;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          if (ptr == PTR_LAST) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output word decodes only flops, so it is steady for as long as the word is stalled.
  always_comb begin
    word = '0;
    if (state == ST_DRAIN) begin
      word.missing = !mask[ptr];
      word.last    = (ptr == PTR_LAST);
      word.cls     = node_cls[ptr[PTR_W-1:1]];
      word.node    = ptr[PTR_W-1:1];
      word.idx     = ptr[0];
      word.data    = mask[ptr] ? q_vec[ptr] : '0;
    end
  end

  assign io.in_ready    = (state == ST_COLLECT);
  assign io.busy        = (state != ST_IDLE);
  assign io.timeout     = timeout_q;
  assign io.res_valid   = (state == ST_DRAIN);
  assign io.res_data    = word.data;
  assign io.res_node    = word.node;
  assign io.res_idx     = word.idx;
  assign io.res_class   = word.cls;
  assign io.res_missing = word.missing;
  assign io.res_last    = word.last;
endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed and randomized frames for gnn_result_collector, checked against a frame-level model
// that predicts captures, timeout, word contents and class from ready times and data values.
module tb_gnn_result_collector;
  localparam int T  = 8;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gnn_result_collector_if #(.NUM_NODES(4), .DATA_W(21)) bus ();

  gnn_result_collector #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Per-frame stimulus: collect cycle at which each result's ready rises (large = never),
  // the value presented on that cycle, and stall cycles before each word is accepted.
  int          rc    [NR];
  logic [20:0] val   [NR];
  int          stall [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sval(input logic [20:0] v);
    int u;
    u = int'(v);
    return v[20] ? u - (1 << 21) : u;
  endfunction

  task automatic set_default();
    for (int p = 0; p < NR; p++) begin
      rc[p]    = 3;
      val[p]   = 21'($urandom);
      stall[p] = 0;
    end
  endtask

  task automatic drive_collect(input int c);
    for (int p = 0; p < NR; p++) begin
      logic [20:0] v;
      int n;
      n = p / 2;
      v = (c == rc[p]) ? val[p] : 21'($urandom);
      if (p % 2 == 0) begin
        bus.out10_rdy[n] = (rc[p] <= c);
        bus.out0_bus[n*21 +: 21] = v;
      end else begin
        bus.out11_rdy[n] = (rc[p] <= c);
        bus.out1_bus[n*21 +: 21] = v;
      end
    end
  endtask

  task automatic run_frame(input int abort_word, input bit start_on_last);
    int          mx;
    int          kend;
    bit          to;
    bit          cap [NR];
    bit          cls [4];
    logic [20:0] edat;
    mx = 0;
    for (int p = 0; p < NR; p++) if (rc[p] > mx) mx = rc[p];
    to   = (mx > T - 1);
    kend = to ? T - 1 : mx;
    for (int p = 0; p < NR; p++) cap[p] = (rc[p] <= kend);
    for (int n = 0; n < 4; n++)
      cls[n] = cap[2*n] && cap[2*n+1] && (sval(val[2*n+1]) > sval(val[2*n]));

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_collect", 32'(bus.busy), 32'd1);
    chk("timeout_cleared", 32'(bus.timeout), 32'd0);
    for (int c = 0; c <= kend; c++) begin
      chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
      chk("valid_collect", 32'(bus.res_valid), 32'd0);
      drive_collect(c);
      tick();
    end
    bus.out10_rdy = '0;
    bus.out11_rdy = '0;
    bus.out0_bus  = 84'({$urandom, $urandom, $urandom});
    bus.out1_bus  = 84'({$urandom, $urandom, $urandom});
    chk("in_ready_drain", 32'(bus.in_ready), 32'd0);

    for (int w = 0; w < NR; w++) begin
      edat = cap[w] ? val[w] : 21'd0;
      for (int s = 0; s <= stall[w]; s++) begin
        bus.res_ready = (s == stall[w]);
        if (abort_word == w) begin
          rst_n = 1'b0;
          #1;
          chk("rst_valid", 32'(bus.res_valid), 32'd0);
          chk("rst_busy_inready", {30'd0, bus.busy, bus.in_ready}, 32'd0);
          chk("rst_fields", {bus.res_last, bus.res_missing, bus.res_class, bus.res_idx,
                             bus.res_node, 6'd0, bus.res_data}, 32'd0);
          chk("rst_timeout", 32'(bus.timeout), 32'd0);
          tick();
          tick();
          rst_n = 1'b1;
          tick();
          chk("post_rst_busy", 32'(bus.busy), 32'd0);
          chk("post_rst_valid", 32'(bus.res_valid), 32'd0);
          return;
        end
        chk("word_valid", 32'(bus.res_valid), 32'd1);
        chk("word_data", 32'(bus.res_data), 32'(edat));
        chk("word_tag", {29'd0, bus.res_node, bus.res_idx}, 32'(w));
        chk("word_flags", {29'd0, bus.res_missing, bus.res_last, bus.res_class},
            {29'd0, !cap[w], (w == NR - 1), cls[w/2]});
        if (w == NR - 1 && s == stall[w] && start_on_last) bus.start = 1'b1;
        tick();
      end
    end
    chk("end_valid", 32'(bus.res_valid), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_timeout", 32'(bus.timeout), 32'(to));
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.out0_bus  = '0;
    bus.out1_bus  = '0;
    bus.out10_rdy = '0;
    bus.out11_rdy = '0;
    bus.res_ready = 1'b1;
    #2;
    chk("reset_valid", 32'(bus.res_valid), 32'd0);
    chk("reset_ctrl", {29'd0, bus.busy, bus.in_ready, bus.timeout}, 32'd0);
    chk("reset_word", {bus.res_last, bus.res_missing, bus.res_class, bus.res_idx,
                       bus.res_node, 6'd0, bus.res_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Normal frame; start held during the last transfer must not relaunch.
    set_default();
    val[0] = 21'h000123;
    val[1] = 21'h000456;
    run_frame(-1, 1'b1);

    // Staggered ready; data on the bus changes after each capture.
    set_default();
    for (int p = 0; p < NR; p++) rc[p] = (p % 2 == 0) ? 2 : 6;
    run_frame(-1, 1'b0);

    // Back-pressure on word 2.
    set_default();
    stall[2] = 3;
    run_frame(-1, 1'b0);

    // Node2 out1 never ready: drain after timeout, sticky flag until next start.
    set_default();
    rc[5] = 1000;
    run_frame(-1, 1'b0);
    tick();
    chk("timeout_sticky", 32'(bus.timeout), 32'd1);

    // Signed class compare.
    set_default();
    val[2] = 21'h1FFFFF; val[3] = 21'h000000;
    val[4] = 21'h000010; val[5] = 21'h000010;
    val[6] = 21'h100000; val[7] = 21'h000001;
    run_frame(-1, 1'b0);

    // Reset during word 3, then a full frame.
    set_default();
    run_frame(3, 1'b0);
    set_default();
    run_frame(-1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      for (int p = 0; p < NR; p++) begin
        rc[p]    = $urandom_range(0, T + 1);
        val[p]   = 21'($urandom);
        stall[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      if (f % 4 == 0)
        for (int p = 0; p < NR; p++) rc[p] = $urandom_range(0, T - 1);
      run_frame(-1, f[0]);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
